// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//   Generates a word-addressed fetch PC and issues requests over an in-order
//   grant/response memory interface. Returned instructions are collected in a
//   small prefetch FIFO. The FIFO head is presented to IF/ID as {pc, instr},
//   one pair per cycle. Redirects flush the FIFO and mark responses that are
//   still in flight for discard. A stalled decode stage holds the head.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   stall_if            decode stalled; hold the presented instruction
//   redirect_valid/_pc  control-flow change and its new fetch target
//   imem_req/_addr      request valid and word address (never depends on gnt)
//   imem_gnt            memory accepts the request this cycle
//   imem_rvalid/_rdata  in-order response
//   if_valid/_pc/_instr presented instruction (NOP_INSTR and pc 0 when empty)
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [15:0] NOP_INSTR = 16'hE000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_pc,
    output logic [15:0] if_instr
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int SW = CW + 1;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_ent_t;

    logic [15:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_cnt;

    // PC of every accepted request, popped by every response (kept or dropped).
    logic [15:0]   pcq [BUF_DEPTH];
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;

    fetch_ent_t    fifo [BUF_DEPTH];
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;

    logic          pop;
    logic          push;
    logic          req_fire;
    logic [SW-1:0] credit_use;

    assign if_valid = !rst && (fifo_cnt != '0);
    assign pop      = if_valid && !stall_if && !redirect_valid;

    // The slot freed by this cycle's pop is counted as available so a new
    // request can go out every cycle in steady state.
    assign credit_use = SW'(outstanding) + SW'(fifo_cnt) - SW'(pop);
    assign imem_req   = !rst && !redirect_valid && (credit_use < SW'(BUF_DEPTH));
    assign imem_addr  = fetch_pc;
    assign req_fire   = imem_req && imem_gnt;

    // A response landing in a redirect cycle belongs to the old stream.
    assign push = imem_rvalid && !redirect_valid && (discard == '0);

    always_comb begin
        if_pc    = 16'h0000;
        if_instr = NOP_INSTR;
        if (if_valid) begin
            if_pc    = fifo[fifo_rd].pc;
            if_instr = fifo[fifo_rd].instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_cnt    <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            if (req_fire) begin
                pcq[pcq_wr] <= fetch_pc;
                pcq_wr      <= pcq_wr + 1'b1;
            end
            if (imem_rvalid)
                pcq_rd <= pcq_rd + 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rvalid);

            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                // Everything still in flight after this cycle is stale.
                discard  <= outstanding - CW'(imem_rvalid);
                fifo_cnt <= '0;
                fifo_wr  <= '0;
                fifo_rd  <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 16'd1;
                if (imem_rvalid && (discard != '0))
                    discard <= discard - 1'b1;
                if (push) begin
                    fifo[fifo_wr] <= '{pc: pcq[pcq_rd], instr: imem_rdata};
                    fifo_wr       <= fifo_wr + 1'b1;
                end
                if (pop)
                    fifo_rd <= fifo_rd + 1'b1;
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            end
        end
    end

    // Credit accounting must keep the FIFO from overflowing and responses
    // from arriving without a matching request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (fifo_cnt == CW'(BUF_DEPTH))));
            assert (!(imem_rvalid && (outstanding == '0)));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP      = 16'hE000;
    localparam logic [15:0] KEY      = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst, stall_if, redirect_valid, imem_req, imem_gnt, imem_rvalid, if_valid;
    logic [15:0] redirect_pc, imem_addr, imem_rdata, if_pc, if_instr;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        nchk++;
        $display("FAIL %s: timed out waiting, expected event did not occur", name);
    endtask

    // Memory model: fixed latency per phase, so responses stay in order.
    typedef struct { logic [15:0] addr; int due; } pend_t;
    pend_t pend[$];
    int    cur = -1;
    int    lat = 1;

    // Reference model: the consumed stream is the sequential PC sequence
    // starting at the last redirect target (or RESET_PC), instr = pc ^ KEY.
    logic [15:0] exp_q[$];

    task automatic restart_stream(input logic [15:0] base);
        exp_q.delete();
        for (int k = 0; k < 512; k++) exp_q.push_back(base + 16'(k));
    endtask

    // One cycle: drive at negedge, sample at negedge+1.
    task automatic cyc(input logic r, input logic st, input logic rd,
                       input logic [15:0] rpc, input logic g);
        @(negedge clk);
        cur++;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        if (r) pend.delete();
        else if (pend.size() > 0 && pend[0].due == cur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ KEY;
            pend.delete(0);
        end
        rst = r; stall_if = st; redirect_valid = rd; redirect_pc = rpc; imem_gnt = g;
        if (r) restart_stream(RESET_PC);
        else if (rd) restart_stream(rpc);
        #1;
        if (imem_req && imem_gnt) pend.push_back('{addr: imem_addr, due: cur + lat});
    endtask

    task automatic wait_valid(input string name, input logic [15:0] exp_pc);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
            if (if_valid) begin
                found = 1'b1;
                chk(name, if_pc, exp_pc);
            end
        end
        if (!found) fail_timeout(name);
    endtask

    // Monitor / scoreboard, decoupled from stimulus.
    logic        mon_hold = 1'b0;
    logic [15:0] mon_hold_pc = 16'h0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b1) begin
                chk("rst_valid", if_valid, 1'b0);
                chk("rst_pc", if_pc, 16'h0000);
                chk("rst_instr", if_instr, NOP);
                chk("rst_req", imem_req, 1'b0);
                mon_hold = 1'b0;
            end else if (rst === 1'b0) begin
                if (mon_hold) begin
                    chk("hold_valid", if_valid, 1'b1);
                    chk("hold_pc", if_pc, mon_hold_pc);
                end
                if (!if_valid) begin
                    chk("idle_pc", if_pc, 16'h0000);
                    chk("idle_instr", if_instr, NOP);
                end else if (!stall_if && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        nchk++;
                        $display("FAIL stream: unexpected output pc %h, expected none", if_pc);
                    end else begin
                        chk("stream_pc", if_pc, exp_q[0]);
                        chk("stream_instr", if_instr, exp_q[0] ^ KEY);
                        exp_q.delete(0);
                    end
                end
                mon_hold    = if_valid && stall_if && !redirect_valid;
                mon_hold_pc = if_pc;
            end
        end
    end

    logic [15:0] wrap_exp [4];
    logic [15:0] held_addr;
    logic        hold_chk, g;
    int          nv;
    bit          found;

    initial begin
        wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        rst = 1'b1; stall_if = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0;

        // Reset, then sequential full throughput with latency-1 memory.
        lat = 1;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        cur = -1;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
            if (i < 3) chk("seq_addr", imem_addr, i);
            if (i < 2) chk("seq_valid_early", if_valid, 1'b0);
            else begin
                chk("seq_valid", if_valid, 1'b1);
                chk("seq_pc", if_pc, i - 2);
            end
        end

        // Stall while pc 5 is presented.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
            chk("stall_pc", if_pc, 16'h0005);
            chk("stall_req", imem_req, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
            chk("release_valid", if_valid, 1'b1);
            chk("release_pc", if_pc, 5 + i);
        end

        // Redirect with one request in flight.
        cyc(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1);
        chk("redir_req", imem_req, 1'b0);
        wait_valid("redir_first_pc", 16'h0040);

        // Latency-3 memory, redirect coincident with a response.
        lat = 3;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'($urandom));
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (pend.size() > 0 && pend[0].due == cur + 1) begin
                found = 1'b1;
                cyc(1'b0, 1'b0, 1'b1, 16'h0123, 1'b1);
                chk("lat3_redir_req", imem_req, 1'b0);
            end else cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        end
        if (!found) fail_timeout("lat3_coincident");
        wait_valid("lat3_first_pc", 16'h0123);

        // Back-to-back redirects until memory drains, then wrap with gnt toggling.
        for (int k = 0; k < 10 && pend.size() > 0; k++) cyc(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1);
        lat = 1;
        g = 1'b1; nv = 0; hold_chk = 1'b0; held_addr = 16'h0;
        for (int k = 0; k < 30 && nv < 4; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0, g);
            if (hold_chk) begin
                chk("gnt_hold_req", imem_req, 1'b1);
                chk("gnt_hold_addr", imem_addr, held_addr);
            end
            hold_chk  = imem_req && !imem_gnt;
            held_addr = imem_addr;
            if (if_valid) begin
                chk("wrap_pc", if_pc, wrap_exp[nv]);
                nv++;
            end
            g = ~g;
        end
        if (nv < 4) fail_timeout("wrap_seq");

        // Reset with the FIFO full.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        chk("full_valid", if_valid, 1'b1);
        chk("full_req", imem_req, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("post_rst_valid", if_valid, 1'b0);
        chk("post_rst_instr", if_instr, NOP);
        chk("post_rst_pc", if_pc, 16'h0000);
        chk("post_rst_req", imem_req, 1'b1);
        chk("post_rst_addr", imem_addr, RESET_PC);

        // Randomized segments, each with its own memory latency.
        for (int s = 0; s < 4; s++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
            lat = $urandom_range(1, 4);
            for (int k = 0; k < 400; k++) begin
                cyc(1'b0,
                    $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 6,
                    $urandom_range(0, 1) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15)),
                    $urandom_range(0, 99) < 75);
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that generates the PC and issues requests to instruction memory over a grant/response interface.
- Holds returned instructions in a small in-order prefetch buffer and presents one {pc, instr} pair per cycle to the IF/ID pipeline register.
- Handles branch/jump redirects by flushing the buffer and discarding in-flight responses.
- Handles back-pressure from a stalled decode stage by holding the buffer head.

Parameters:
- RESET_PC, 16'h0000, fetch PC loaded on reset.
- BUF_DEPTH, 2, prefetch buffer entries; power of 2, >=2; also the cap on outstanding requests.
- NOP_INSTR, 16'hE000, instruction presented when no valid instruction is available.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- stall_if  input  1  decode stalled; hold the buffer head.
- redirect_valid  input  1  control-flow change resolved downstream.
- redirect_pc  input  16  new fetch target.
- imem_req  output  1  request valid.
- imem_addr  output  16  word address of the request.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response valid; responses return in order.
- imem_rdata  input  16  response instruction.
- if_valid  output  1  if_pc/if_instr hold a real instruction.
- if_pc  output  16  PC of the presented instruction.
- if_instr  output  16  presented instruction.

Behaviour:
- Word-addressed PC.
  - A request transfers when imem_req && imem_gnt; fetch_pc then becomes fetch_pc+1, wrapping 16'hFFFF -> 16'h0000.
  - imem_addr = fetch_pc.
- State:
  - fetch_pc.
  - outstanding counter, 0..BUF_DEPTH.
  - discard counter, 0..BUF_DEPTH.
  - in-flight PC queue of BUF_DEPTH entries holding the PC of each accepted request.
  - prefetch FIFO of BUF_DEPTH entries, each {pc, instr}.
- Reset (rst=1 at clock edge):
  - fetch_pc=RESET_PC; FIFO, PC queue and both counters cleared.
  - While rst=1: imem_req=0, if_valid=0, if_pc=16'h0000, if_instr=NOP_INSTR.
- pop = if_valid && !stall_if && !redirect_valid.
- imem_req = !rst && !redirect_valid && (outstanding + occupancy - pop < BUF_DEPTH).
  - Counting the same-cycle pop is required so the block sustains 1 instr/cycle.
  - imem_req/imem_addr must not depend combinationally on imem_gnt.
- Response handling:
  - discard>0: response dropped, discard decremented, PC queue popped.
  - Otherwise {pc_queue head, imem_rdata} is pushed to the FIFO.
  - In both cases outstanding is decremented.
  - The credit rule guarantees the FIFO never overflows; a push into a full FIFO is a design error (assertion).
- Outputs:
  - FIFO non-empty: if_valid=1, if_pc/if_instr = FIFO head.
  - FIFO empty: if_valid=0, if_pc=16'h0000, if_instr=NOP_INSTR.
  - No bypass: a response is visible on if_* the cycle after imem_rvalid.
  - Minimum latency is grant at cycle T, rvalid at T+1, if_valid at T+2.
- Stall: stall_if=1 with no redirect holds the head stable. Fetching continues until credits run out.
- Redirect (redirect_valid=1), which has priority over stall and over pop:
  - Same cycle: imem_req=0 and the FIFO is cleared at the edge.
  - Next cycle: fetch_pc = redirect_pc.
  - discard = outstanding - (imem_rvalid ? 1 : 0). A response arriving in the redirect cycle is dropped and is not written to the FIFO.
  - outstanding decrements normally.
  - Back-to-back redirects: the last one wins, and discard is recomputed from the current outstanding each time.
- Wrap-around: a sequential fetch past 16'hFFFF continues at 16'h0000 with no special action.
- A reset mid-transaction abandons in-flight responses. The memory model is reset together with this block.

Test Plan:
- Sequential, full throughput: latency-1 memory with imem_gnt=1 always, rst released at cycle 0. Expected:
  - imem_addr 0,1,2,... on cycles 0,1,2.
  - if_valid first high on cycle 2 with if_pc=0, then if_pc 1,2,3 on consecutive cycles.
  - imem_rdata=pc^16'hA5A5 appears on if_instr.
- Stall: stall_if=1 for 4 cycles while if_pc=5. Expected:
  - if_pc holds 5 throughout.
  - imem_req drops once outstanding+occupancy reaches 2.
  - After release, if_pc 6,7 follow with no gap and no duplicate.
- Redirect with in-flight: pulse redirect_valid with redirect_pc=16'h0040 while 1 request is outstanding. Expected:
  - The stale response is dropped.
  - The next if_valid shows if_pc=16'h0040.
  - No instruction from the old stream appears.
- Redirect coincident with imem_rvalid under latency-3 memory: every stale response is discarded and the first valid output is the redirect target.
- Wrap and grant back-pressure: redirect to 16'hFFFE with imem_gnt toggling 1,0. Expected:
  - if_pc sequence FFFE, FFFF, 0000, 0001.
  - imem_addr holds while imem_gnt=0.
- Reset mid-stream: assert rst for 1 cycle with FIFO full. Expected:
  - Next cycle if_valid=0, if_instr=16'hE000, if_pc=0.
  - The first request after release has imem_addr=RESET_PC.
